// File: rtl/classifier_channel_scheduler_pkg.sv
// classifier_pkg: class codes and scheduler state encoding shared by the scheduler slice
package classifier_pkg;
  localparam logic [1:0] CLASS_C = 2'd0;
  localparam logic [1:0] CLASS_B = 2'd1;
  localparam logic [1:0] CLASS_A = 2'd2;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} sched_state_t;
endpackage

// File: rtl/classifier_channel_scheduler_if.sv
// classifier_channel_scheduler_if: request/response link between the scheduler and the shared classifier core
// master = scheduler (drives core_req_valid, core_ch, core_det); slave = core (drives ready and the response)
interface classifier_channel_scheduler_if #(parameter int CH_W = 3);
  logic            core_req_valid;
  logic            core_req_ready;
  logic [CH_W-1:0] core_ch;
  logic            core_det;
  logic            core_rsp_valid;
  logic [1:0]      core_rsp_class;
  modport master (output core_req_valid, core_ch, core_det, input core_req_ready, core_rsp_valid, core_rsp_class);
  modport slave  (input core_req_valid, core_ch, core_det, output core_req_ready, core_rsp_valid, core_rsp_class);
endinterface

// File: rtl/classifier_channel_scheduler_sched_timeout_cnt.sv
// sched_timeout_cnt: response-wait counter, o_expired high on the TIMEOUT_CYC-th enabled cycle after a clear
// Ports: clk, reset_n (async, active-low), i_clr (zero the count), i_en (count this cycle), o_expired
module sched_timeout_cnt #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);
  localparam int W = $clog2(TIMEOUT_CYC + 1);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en && !o_expired) r_cnt <= r_cnt + 1'b1;
  assign o_expired = r_cnt == W'(TIMEOUT_CYC - 1);
endmodule

// File: rtl/classifier_channel_scheduler.sv
// classifier_channel_scheduler: time-multiplexes one shared classifier core across NUM_CH channels per frame
// Ports: clk, reset_n (async, active-low); sample_tick + det_in start a frame; core = master side of the
// core link; class_out/class_update publish a whole frame atomically; busy, frame_overrun (dropped tick),
// err_timeout (sticky response timeout). Build option CLASSIFIER_CH_MASK_EN adds ch_enable: disabled
// channels are skipped and publish class 0.
module classifier_channel_scheduler
  import classifier_pkg::*;
#(
  parameter int NUM_CH      = 8,
  parameter int CH_W        = $clog2(NUM_CH),
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sample_tick,
  input  logic [NUM_CH-1:0]     det_in,
`ifdef CLASSIFIER_CH_MASK_EN
  input  logic [NUM_CH-1:0]     ch_enable,
`endif
  classifier_channel_scheduler_if.master core,
  output logic [2*NUM_CH-1:0]   class_out,
  output logic                  class_update,
  output logic                  busy,
  output logic                  frame_overrun,
  output logic                  err_timeout
);
  sched_state_t        r_state, w_state_nxt;
  logic [CH_W-1:0]     r_ch;
  logic [NUM_CH-1:0]   r_det_lat, w_en, w_tick_en;
  logic [2*NUM_CH-1:0] r_shadow, w_shadow_nxt, w_keep;
  logic [CH_W:0]       w_first, w_next;
  logic                w_tick_ok, w_adv, w_expired;
`ifdef CLASSIFIER_CH_MASK_EN
  logic [NUM_CH-1:0]   r_en;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_en <= '0;
    else if (w_tick_ok) r_en <= ch_enable;
  assign w_en      = r_en;
  assign w_tick_en = ch_enable;
`else
  assign w_en      = '1;
  assign w_tick_en = '1;
`endif
  // {found, index} of the lowest set bit of m at or above from
  function automatic logic [CH_W:0] find_en(input logic [NUM_CH-1:0] m, input int from);
    find_en = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (i >= from && m[i]) find_en = {1'b1, CH_W'(i)};
  endfunction
  assign w_tick_ok = sample_tick && r_state == S_IDLE;
  assign w_adv     = r_state == S_WAIT && (core.core_rsp_valid || w_expired);
  assign w_first   = find_en(w_tick_en, 0);
  assign w_next    = find_en(w_en, int'(r_ch) + 1);
  sched_timeout_cnt #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_clr    (r_state != S_WAIT),
    .i_en     (r_state == S_WAIT),
    .o_expired(w_expired)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= S_IDLE;
    else r_state <= w_state_nxt;
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = !w_tick_ok ? S_IDLE : w_first[CH_W] ? S_ISSUE : S_DONE;
      S_ISSUE: w_state_nxt = core.core_req_ready ? S_WAIT : S_ISSUE;
      S_WAIT:  w_state_nxt = !w_adv ? S_WAIT : w_next[CH_W] ? S_ISSUE : S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end
  always_comb begin
    core.core_req_valid = r_state == S_ISSUE;
    core.core_ch        = r_ch;
    core.core_det       = r_det_lat[r_ch];
    class_update        = r_state == S_DONE;
    busy                = r_state != S_IDLE;
    frame_overrun       = sample_tick && r_state != S_IDLE;
  end
  // shadow as it will be after this edge; disabled channels are zeroed when their frame is accepted
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) w_keep[2*i +: 2] = {2{w_tick_en[i]}};
    w_shadow_nxt = r_shadow;
    if (w_tick_ok) w_shadow_nxt = r_shadow & w_keep;
    if (r_state == S_WAIT && core.core_rsp_valid) w_shadow_nxt[2*r_ch +: 2] = core.core_rsp_class;
  end
  // class_out loads on DONE entry (including the last response) so it is valid while class_update pulses
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_ch        <= '0;
      r_det_lat   <= '0;
      r_shadow    <= '0;
      class_out   <= '0;
      err_timeout <= 1'b0;
    end else begin
      r_shadow <= w_shadow_nxt;
      if (w_tick_ok) begin
        r_det_lat <= det_in;
        r_ch      <= w_first[CH_W-1:0];
      end else if (w_adv && w_next[CH_W]) r_ch <= w_next[CH_W-1:0];
      if (w_state_nxt == S_DONE && r_state != S_DONE) class_out <= w_shadow_nxt;
      if (w_adv && !core.core_rsp_valid) err_timeout <= 1'b1;
    end
endmodule

// File: tb/tb_classifier_channel_scheduler.sv
// tb_classifier_channel_scheduler: randomized self-checking bench with a behavioural core and frame model
module tb_classifier_channel_scheduler;
  import classifier_pkg::*;
  localparam int N  = 4;
  localparam int TO = 64;
  logic clk = 1'b0, reset_n = 1'b0, sample_tick = 1'b0;
  logic [N-1:0] det_in = '0;
`ifdef CLASSIFIER_CH_MASK_EN
  logic [N-1:0] ch_enable = '1;
`endif
  logic [2*N-1:0] class_out;
  logic class_update, busy, frame_overrun, err_timeout;
  classifier_channel_scheduler_if #(.CH_W(2)) core ();
  classifier_channel_scheduler #(.NUM_CH(N), .TIMEOUT_CYC(TO)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_tick  (sample_tick),
    .det_in       (det_in),
`ifdef CLASSIFIER_CH_MASK_EN
    .ch_enable    (ch_enable),
`endif
    .core         (core),
    .class_out    (class_out),
    .class_update (class_update),
    .busy         (busy),
    .frame_overrun(frame_overrun),
    .err_timeout  (err_timeout)
  );
  always #5 clk = ~clk;
  int total = 0, bad = 0;
  logic [1:0] cls[N];
  int dly[N];
  bit drop[N];
  logic [N-1:0] en_mask = '1;
  logic [1:0] exp_cls[N];
  bit exp_err;
  bit rand_rdy;
  logic [2:0] log_q[$];
  // behavioural core: logs each accepted request, answers dly[ch] cycles later unless drop[ch]
  initial begin
    int c;
    core.core_rsp_valid = 1'b0;
    core.core_rsp_class = 2'd0;
    forever begin
      @(negedge clk);
      if (reset_n && core.core_req_valid && core.core_req_ready) begin
        c = int'(core.core_ch);
        log_q.push_back({core.core_ch, core.core_det});
        @(posedge clk); #1;
        if (!drop[c]) begin
          repeat (dly[c] - 1) begin @(posedge clk); #1; end
          core.core_rsp_valid = 1'b1;
          core.core_rsp_class = cls[c];
          @(posedge clk); #1;
          core.core_rsp_valid = 1'b0;
          core.core_rsp_class = 2'($urandom);
        end
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  function automatic logic [2*N-1:0] exp_vec();
    for (int i = 0; i < N; i++) exp_vec[2*i +: 2] = exp_cls[i];
  endfunction
  task automatic set_core(input bit rnd);
    for (int i = 0; i < N; i++) begin
      cls[i]  = 2'($urandom_range(0, 2));
      dly[i]  = rnd ? int'($urandom_range(1, 4)) : 1;
      drop[i] = 1'b0;
    end
  endtask
  // one frame: tick in cycle 0, lat counts cycles after it; the model updates expectations at frame end
  task automatic do_frame(input logic [N-1:0] det, input int exp_lat, input int stall_from,
                          input int stall_len, input int tick2_at, output int err_at);
    int lat, n_ovr, k;
    bit got;
    logic [2*N-1:0] prev;
    prev = class_out; got = 0; n_ovr = 0; lat = 0; err_at = -1;
    log_q.delete();
    @(posedge clk); #1;
    sample_tick = 1'b1; det_in = det; core.core_req_ready = 1'b1;
`ifdef CLASSIFIER_CH_MASK_EN
    ch_enable = en_mask;
`endif
    while (!got && lat < 400) begin
      @(posedge clk); #1;
      lat++;
      sample_tick = lat == tick2_at;
      det_in = N'($urandom);
`ifdef CLASSIFIER_CH_MASK_EN
      ch_enable = N'($urandom);
`endif
      core.core_req_ready = rand_rdy ? $urandom_range(0, 2) != 0 : !(lat >= stall_from && lat < stall_from + stall_len);
      @(negedge clk);
      if (frame_overrun) n_ovr++;
      if (err_timeout && err_at < 0) err_at = lat;
      if (lat >= stall_from && lat < stall_from + stall_len) begin
        total++;
        if (core.core_req_valid !== 1'b1 || int'(core.core_ch) != (stall_from - 1) / 2 || core.core_det !== det[(stall_from - 1) / 2]) begin
          bad++;
          $display("FAIL stall_hold cyc %0d: valid=%b ch=%0d det=%b want 1/%0d/%b", lat, core.core_req_valid, core.core_ch, core.core_det, (stall_from - 1) / 2, det[(stall_from - 1) / 2]);
        end
      end
      if (class_update) got = 1;
      else begin
        total++;
        if (class_out !== prev) begin bad++; $display("FAIL early_class_out cyc %0d: got %h want %h", lat, class_out, prev); end
      end
    end
    sample_tick = 1'b0; core.core_req_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      exp_cls[i] = !en_mask[i] ? CLASS_C : drop[i] ? exp_cls[i] : cls[i];
      if (en_mask[i] && drop[i]) exp_err = 1;
    end
    total++;
    if (!got) begin bad++; $display("FAIL frame_done: no class_update within %0d cycles", lat); end
    if (exp_lat > 0) begin
      total++;
      if (lat != exp_lat) begin bad++; $display("FAIL latency: got %0d want %0d", lat, exp_lat); end
    end
    total++;
    if (class_out !== exp_vec()) begin bad++; $display("FAIL class_out: got %b want %b", class_out, exp_vec()); end
    k = 0;
    for (int i = 0; i < N; i++) if (en_mask[i]) begin
      total++;
      if (k >= log_q.size() || log_q[k] !== {2'(i), det[i]}) begin
        bad++;
        $display("FAIL request_%0d: got %b want %b", k, k < log_q.size() ? log_q[k] : 3'bxxx, {2'(i), det[i]});
      end
      k++;
    end
    total++;
    if (log_q.size() != k) begin bad++; $display("FAIL request_count: got %0d want %0d", log_q.size(), k); end
    total++;
    if (err_timeout !== exp_err) begin bad++; $display("FAIL err_timeout: got %b want %b", err_timeout, exp_err); end
    total++;
    if (n_ovr != (tick2_at > 0 ? 1 : 0)) begin bad++; $display("FAIL overrun_pulses: got %0d want %0d", n_ovr, tick2_at > 0 ? 1 : 0); end
  endtask
  task automatic test_reset();
    reset_n = 1'b0; sample_tick = 1'b1; core.core_req_ready = 1'b1;
    for (int i = 0; i < N; i++) exp_cls[i] = CLASS_C;
    exp_err = 0;
    repeat (3) @(negedge clk);
    total++;
    if ({class_out, class_update, busy, frame_overrun, err_timeout, core.core_req_valid, core.core_ch, core.core_det} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got cls=%h upd=%b busy=%b ovr=%b err=%b v=%b ch=%0d det=%b want all 0",
               class_out, class_update, busy, frame_overrun, err_timeout, core.core_req_valid, core.core_ch, core.core_det);
    end
    @(posedge clk); #1;
    sample_tick = 1'b0; reset_n = 1'b1;
  endtask
  task automatic test_basic();
    int e;
    set_core(0);
    cls[0] = CLASS_A; cls[1] = CLASS_B; cls[2] = CLASS_C; cls[3] = CLASS_A;
    do_frame(4'b1011, 1 + 2 * N, -10, 0, -1, e);
    total++;
    if (class_out !== 8'b10_00_01_10) begin bad++; $display("FAIL basic_class_out: got %b want 10000110", class_out); end
  endtask
  task automatic test_det_seq();
    int e;
    logic [N-1:0] seen;
    set_core(0);
    do_frame(4'b0101, 1 + 2 * N, -10, 0, -1, e);
    seen = '0;
    for (int i = 0; i < N && i < log_q.size(); i++) seen[i] = log_q[i][0];
    total++;
    if (seen !== 4'b0101) begin bad++; $display("FAIL det_sequence: got %b want 0101", seen); end
  endtask
  task automatic test_stall_overrun();
    int e;
    set_core(0);
    do_frame(N'($urandom), 1 + 2 * N + 5, 3, 5, 5, e);
    repeat (15) begin
      @(negedge clk);
      total++;
      if (class_update || busy) begin bad++; $display("FAIL extra_frame: upd=%b busy=%b want 0/0", class_update, busy); end
    end
  endtask
  task automatic test_expiry_boundary();
    int e;
    set_core(0);
    cls[2] = 2'((exp_cls[2] + 1) % 3);
    dly[2] = TO;
    do_frame(N'($urandom), 1 + 2 * N + TO - 1, -10, 0, -1, e);
    total++;
    if (e != -1) begin bad++; $display("FAIL expiry_response_wins: err set at cycle %0d want never", e); end
  endtask
  task automatic test_timeout();
    int e;
    set_core(0);
    cls[2] = 2'((exp_cls[2] + 1) % 3);
    drop[2] = 1'b1;
    do_frame(N'($urandom), 1 + 2 * N + TO - 1, -10, 0, -1, e);
    total++;
    if (e != 5 + TO + 1) begin bad++; $display("FAIL timeout_cycle: got %0d want %0d", e, 5 + TO + 1); end
    set_core(0);
    do_frame(N'($urandom), 1 + 2 * N, -10, 0, -1, e);
  endtask
  task automatic test_random();
    int e;
    rand_rdy = 1;
    repeat (6) begin
      set_core(1);
      do_frame(N'($urandom), -1, -10, 0, -1, e);
    end
    rand_rdy = 0;
  endtask
  task automatic test_reset_mid();
    int e;
    set_core(0);
    drop[1] = 1'b1;
    @(posedge clk); #1; sample_tick = 1'b1; det_in = N'($urandom);
    @(posedge clk); #1; sample_tick = 1'b0;
    repeat (3) @(posedge clk);
    #1; reset_n = 1'b0; #1;
    total++;
    if ({class_out, busy, err_timeout, class_update, core.core_req_valid, core.core_ch} !== '0) begin
      bad++;
      $display("FAIL reset_mid: got cls=%h busy=%b err=%b upd=%b v=%b ch=%0d want all 0", class_out, busy, err_timeout, class_update, core.core_req_valid, core.core_ch);
    end
    @(posedge clk); #1; reset_n = 1'b1;
    for (int i = 0; i < N; i++) exp_cls[i] = CLASS_C;
    exp_err = 0;
    set_core(0);
    do_frame(N'($urandom), 1 + 2 * N, -10, 0, -1, e);
  endtask
`ifdef CLASSIFIER_CH_MASK_EN
  task automatic test_mask();
    int e;
    set_core(0);
    en_mask = 4'b1010;
    do_frame(N'($urandom), 5, -10, 0, -1, e);
    total++;
    if (class_out[1:0] !== 2'd0 || class_out[5:4] !== 2'd0) begin bad++; $display("FAIL mask_zero: got %b want xx00xx00", class_out); end
    en_mask = 4'b0000;
    do_frame(N'($urandom), 1, -10, 0, -1, e);
    en_mask = 4'b1111;
    set_core(0);
    do_frame(N'($urandom), 1 + 2 * N, -10, 0, -1, e);
  endtask
`endif
  initial begin
    rand_rdy = 0;
    set_core(0);
    test_reset();
    test_basic();
    test_det_seq();
    test_stall_overrun();
    test_expiry_boundary();
    test_timeout();
    test_random();
    test_reset_mid();
`ifdef CLASSIFIER_CH_MASK_EN
    test_mask();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
